// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg: shared UART widths, buffer geometry and TX FSM state encoding
package uart_tx_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } tx_state_t;
endpackage

// File: rtl/uart_tx_ctrl_baud_gen.sv
// uart_baud_gen: divides tClk by CLK_DIV, bitTick marks the last cycle of each serial bit
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic tClk,
  input  logic tRst,
  input  logic clear,
  output logic bitTick
);
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt;
  assign bitTick = !clear && cnt == W'(CLK_DIV - 1);
  // count cycles within a bit, restarting at every bit boundary or while held clear
  always_ff @(posedge tClk)
    if (!tRst || clear || bitTick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: TX buffer pointer/occupancy control and serial frame generator
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              tClk,
  input  logic              tRst,
  input  logic              hostWr,
  input  logic [DATA_W-1:0] hostData,
  output logic              hostFull,
  output logic              hostEmpty,
  output logic              wrOvf,
  input  logic              txEn,
  output logic              bufWr,
  output logic              bufRd,
  output logic [ADDR_W-1:0] bufAddr,
  output logic [DATA_W-1:0] bufWdata,
  input  logic [DATA_W-1:0] bufRdata,
  output logic              txd,
  output logic              txBusy,
  output logic              txDone
);
  tx_state_t state, state_nxt;
  logic [ADDR_W-1:0] wptr, rptr;
  logic [2:0] count, bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic par, tick, wr_acc, pop, stop_end, txd_nxt, baud_clr;
  assign hostFull = count == 3'(DEPTH);
  assign hostEmpty = count == 3'd0 && state == S_IDLE;
  assign wr_acc = hostWr && !hostFull;
  assign stop_end = state == S_STOP && tick && bit_cnt == 3'(STOP_BITS - 1);
  assign pop = (state == S_IDLE || stop_end) && txEn && count != 3'd0 && !wr_acc;
  assign txBusy = state != S_IDLE;
  assign txDone = stop_end;
  assign baud_clr = state inside {S_IDLE, S_FETCH, S_WAIT, S_LOAD};
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .tClk(tClk),
    .tRst(tRst),
    .clear(baud_clr),
    .bitTick(tick)
  );
  // frame sequencing; txd is precomputed from the next state so the line stays glitch-free
  always_comb begin
    state_nxt = state;
    bit_nxt = bit_cnt;
    shift_nxt = shift;
    case (state)
      S_IDLE: state_nxt = pop ? S_FETCH : S_IDLE;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt = S_START;
        shift_nxt = bufRdata;
        bit_nxt = 3'd0;
      end
      S_START: state_nxt = tick ? S_DATA : S_START;
      S_DATA: if (tick) begin
        shift_nxt = shift >> 1;
        bit_nxt = bit_cnt + 3'd1;
        state_nxt = bit_cnt != 3'd7 ? S_DATA : PARITY_EN != 0 ? S_PARITY : S_STOP;
      end
      S_PARITY: state_nxt = tick ? S_STOP : S_PARITY;
      S_STOP: if (tick) begin
        bit_nxt = bit_cnt + 3'd1;
        state_nxt = !stop_end ? S_STOP : pop ? S_FETCH : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    txd_nxt = state_nxt == S_START ? 1'b0 : state_nxt == S_DATA ? shift_nxt[0] :
              state_nxt == S_PARITY ? par : 1'b1;
  end
  // pointers, occupancy, registered buffer strobes and serial output
  always_ff @(posedge tClk) begin
    if (!tRst) begin
      state <= S_IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      bit_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      txd <= 1'b1;
      bufWr <= 1'b0;
      bufRd <= 1'b0;
      bufAddr <= '0;
      bufWdata <= '0;
      wrOvf <= 1'b0;
    end else begin
      state <= state_nxt;
      bit_cnt <= bit_nxt;
      shift <= shift_nxt;
      txd <= txd_nxt;
      bufWr <= wr_acc;
      bufRd <= pop;
      wrOvf <= hostWr && hostFull;
      count <= count + 3'(wr_acc) - 3'(pop);
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
        bufAddr <= wptr;
        bufWdata <= hostData;
      end else if (pop) bufAddr <= rptr;
      if (pop) rptr <= rptr + 1'b1;
      if (state == S_LOAD) par <= ^bufRdata ^ 1'(PARITY_ODD);
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed vector bench for uart_tx_ctrl with buffer models attached
module tb_uart_tx_ctrl;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst;
  logic wr_a, wr_b, en_a, en_b;
  logic [7:0] hd_a, hd_b;
  logic full_a, full_b, empty_a, empty_b, ovf_a, ovf_b;
  logic bwr_a, bwr_b, brd_a, brd_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic txd_a, txd_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  int n_chk = 0;
  int n_fail = 0;
  int gap;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLK_DIV(DIV)) dut_a (
    .tClk(clk), .tRst(rst), .hostWr(wr_a), .hostData(hd_a), .hostFull(full_a),
    .hostEmpty(empty_a), .wrOvf(ovf_a), .txEn(en_a), .bufWr(bwr_a), .bufRd(brd_a),
    .bufAddr(addr_a), .bufWdata(wdata_a), .bufRdata(rdata_a), .txd(txd_a),
    .txBusy(busy_a), .txDone(done_a)
  );

  uart_tx_ctrl #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .tClk(clk), .tRst(rst), .hostWr(wr_b), .hostData(hd_b), .hostFull(full_b),
    .hostEmpty(empty_b), .wrOvf(ovf_b), .txEn(en_b), .bufWr(bwr_b), .bufRd(brd_b),
    .bufAddr(addr_b), .bufWdata(wdata_b), .bufRdata(rdata_b), .txd(txd_b),
    .txBusy(busy_b), .txDone(done_b)
  );

  always @(posedge clk) begin
    if (bwr_a) mem_a[addr_a] <= wdata_a;
    if (brd_a) rdata_a <= mem_a[addr_a];
    if (bwr_b) mem_b[addr_b] <= wdata_b;
    if (brd_b) rdata_b <= mem_b[addr_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (bwr_a || brd_a) chk("strobe_overlap", 32'(bwr_a & brd_a), 32'd0);

  task automatic run_frame(input bit sel, input logic [11:0] bits, input int nbits,
                           input string nm, output int waited);
    logic [3:0] seen;
    int n = 0;
    int bad_done = 0;
    while ((sel ? txd_b : txd_a) !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (n >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s start: txd never went low within 40 cycles", nm);
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < DIV; c++) begin
        seen[c] = sel ? txd_b : txd_a;
        if ((sel ? done_b : done_a) !== (b == nbits - 1 && c == DIV - 1)) bad_done++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", nm, b), 32'(seen), 32'({4{bits[b]}}));
    end
    chk($sformatf("%s txdone_misplaced_cycles", nm), 32'(bad_done), 32'd0);
  endtask

  typedef struct {
    logic wr; logic [7:0] d;
    logic exp_wr; logic [1:0] exp_addr; logic [7:0] exp_wdata; logic exp_full; logic exp_ovf;
  } wvec_t;

  typedef struct {
    logic [11:0] bits; int exp_gap;
  } fvec_t;

  wvec_t wv [6];
  fvec_t fv [4];

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    wv[0] = '{1'b1, 8'h11, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0};
    wv[1] = '{1'b1, 8'h22, 1'b1, 2'd1, 8'h22, 1'b0, 1'b0};
    wv[2] = '{1'b1, 8'h33, 1'b1, 2'd2, 8'h33, 1'b0, 1'b0};
    wv[3] = '{1'b1, 8'h44, 1'b1, 2'd3, 8'h44, 1'b1, 1'b0};
    wv[4] = '{1'b1, 8'h55, 1'b0, 2'd3, 8'h44, 1'b1, 1'b1};
    wv[5] = '{1'b0, 8'h00, 1'b0, 2'd3, 8'h44, 1'b1, 1'b0};
    fv[0] = '{12'b00_1_00010001_0, 4};
    fv[1] = '{12'b00_1_00100010_0, 3};
    fv[2] = '{12'b00_1_00110011_0, 3};
    fv[3] = '{12'b00_1_01000100_0, 3};

    rst = 1'b0; wr_a = 1'b0; wr_b = 1'b0; en_a = 1'b0; en_b = 1'b0; hd_a = '0; hd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst txd", 32'(txd_a), 32'd1);
    chk("rst strobes", 32'({bwr_a, brd_a, ovf_a, busy_a, done_a}), 32'd0);
    chk("rst addr_wdata", 32'({addr_a, wdata_a}), 32'd0);
    chk("rst empty_full", 32'({empty_a, full_a}), 32'b10);
    rst = 1'b1;

    // single byte 0xA5
    @(negedge clk);
    wr_a = 1'b1; hd_a = 8'hA5; en_a = 1'b1;
    @(negedge clk);
    wr_a = 1'b0;
    chk("t1 bufwr addr wdata", 32'({bwr_a, addr_a, wdata_a}), 32'({1'b1, 2'd0, 8'hA5}));
    run_frame(0, 12'b00_1_10100101_0, 10, "t1 A5", gap);
    chk("t1 gap", 32'(gap), 32'd4);
    chk("t1 idle empty_busy", 32'({empty_a, busy_a}), 32'b10);

    en_a = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // five back-to-back writes with txEn low
    foreach (wv[i]) begin
      wr_a = wv[i].wr; hd_a = wv[i].d;
      @(negedge clk);
      chk($sformatf("t2 row%0d bufwr", i), 32'(bwr_a), 32'(wv[i].exp_wr));
      chk($sformatf("t2 row%0d addr", i), 32'(addr_a), 32'(wv[i].exp_addr));
      chk($sformatf("t2 row%0d wdata", i), 32'(wdata_a), 32'(wv[i].exp_wdata));
      chk($sformatf("t2 row%0d full", i), 32'(full_a), 32'(wv[i].exp_full));
      chk($sformatf("t2 row%0d ovf", i), 32'(ovf_a), 32'(wv[i].exp_ovf));
    end

    // drain four frames, then wrap to addr 0
    en_a = 1'b1;
    foreach (fv[i]) begin
      run_frame(0, fv[i].bits, 10, $sformatf("t3 frame%0d", i), gap);
      chk($sformatf("t3 frame%0d gap", i), 32'(gap), 32'(fv[i].exp_gap));
    end
    chk("t3 empty", 32'(empty_a), 32'd1);
    wr_a = 1'b1; hd_a = 8'h3C;
    @(negedge clk);
    wr_a = 1'b0;
    chk("t3 wrap bufwr addr", 32'({bwr_a, addr_a}), 32'({1'b1, 2'd0}));
    run_frame(0, 12'b00_1_00111100_0, 10, "t3 3C", gap);

    // write collides with a pending pop
    en_a = 1'b0; wr_a = 1'b1; hd_a = 8'h5A;
    @(negedge clk);
    en_a = 1'b1; wr_a = 1'b1; hd_a = 8'h96;
    @(negedge clk);
    wr_a = 1'b0;
    chk("t4 write first", 32'({bwr_a, brd_a, addr_a}), 32'({1'b1, 1'b0, 2'd2}));
    @(negedge clk);
    chk("t4 pop next", 32'({bwr_a, brd_a, addr_a}), 32'({1'b0, 1'b1, 2'd1}));
    run_frame(0, 12'b00_1_01011010_0, 10, "t4 5A", gap);
    chk("t4 5A gap", 32'(gap), 32'd3);
    run_frame(0, 12'b00_1_10010110_0, 10, "t4 96", gap);
    chk("t4 96 gap", 32'(gap), 32'd3);

    // reset during data bit 3
    wr_a = 1'b1; hd_a = 8'h00;
    @(negedge clk);
    wr_a = 1'b0;
    gap = 0;
    while (txd_a !== 1'b0 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    chk("t5 start seen", 32'(gap < 40), 32'd1);
    repeat (17) @(negedge clk);
    chk("t5 mid data", 32'({busy_a, txd_a}), 32'b10);
    rst = 1'b0;
    @(negedge clk);
    chk("t5 after reset txd_busy", 32'({txd_a, busy_a}), 32'b10);
    chk("t5 after reset empty", 32'(empty_a), 32'd1);
    rst = 1'b1; en_a = 1'b0;

    // odd parity, two stop bits
    @(negedge clk);
    wr_b = 1'b1; hd_b = 8'h07; en_b = 1'b1;
    @(negedge clk);
    wr_b = 1'b0;
    run_frame(1, 12'b1_1_0_00000111_0, 12, "t6 07", gap);
    chk("t6 gap", 32'(gap), 32'd4);
    chk("t6 idle empty_busy", 32'({empty_b, busy_b}), 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
